// File: rtl/score_engine.sv
// score_engine
//   Score datapath for the Pacman game FSM. It takes one scoring event per
//   cycle and adds its points to a saturating score. It also tracks a ghost
//   combo multiplier, keeps a high score that survives new games, and emits a
//   one-shot extra-life pulse. The block sits between game_control, which
//   supplies the events, and the HUD / score display.
//
// Ports
//   clk          in   1        system clock, all logic on posedge
//   reset_n      in   1        synchronous reset, active-high (1 = reset)
//   game_clear   in   1        new game: clear score/combo/flags, keep high_score
//   power_start  in   1        power mode begins, combo returns to 0
//   power_end    in   1        power mode ends, combo returns to 0
//   event_valid  in   1        scoring event present
//   event_type   in   2        00 pellet, 01 power pellet, 10 ghost, 11 fruit
//   event_ready  out  1        event accepted this cycle (combinational)
//   score        out  SCORE_W  current score (registered)
//   high_score   out  SCORE_W  best score since reset (registered)
//   combo        out  2        ghost combo level, 0..COMBO_MAX
//   extra_life   out  1        one-cycle pulse on the first crossing of LIFE_THRESH
//   saturated    out  1        sticky flag, score clamped at all-ones
module score_engine #(
  parameter int SCORE_W     = 24,
  parameter int PELLET_PTS  = 10,
  parameter int POWER_PTS   = 50,
  parameter int GHOST_BASE  = 200,
  parameter int FRUIT_PTS   = 100,
  parameter int COMBO_MAX   = 3,
  parameter int LIFE_THRESH = 10000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               game_clear,
  input  logic               power_start,
  input  logic               power_end,
  input  logic               event_valid,
  input  logic [1:0]         event_type,
  output logic               event_ready,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         combo,
  output logic               extra_life,
  output logic               saturated
);

  // The sum is kept wider than SCORE_W + 1 bits. A narrow score must not
  // truncate a shifted ghost value before the overflow check runs, and the
  // extra-life threshold may be larger than the score can hold.
  localparam int SUM_W = ((SCORE_W > 32) ? SCORE_W : 32) + 2;
  localparam logic [SUM_W-1:0] SCORE_MAX  = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [SUM_W-1:0] LIFE_LIMIT = SUM_W'(LIFE_THRESH);
  localparam logic [1:0]       COMBO_TOP  = 2'(COMBO_MAX);

  localparam logic [1:0] EV_PELLET = 2'b00;
  localparam logic [1:0] EV_POWER  = 2'b01;
  localparam logic [1:0] EV_GHOST  = 2'b10;
  localparam logic [1:0] EV_FRUIT  = 2'b11;

  logic             life_given;
  logic             accept;
  logic [SUM_W-1:0] pts;
  logic [SUM_W-1:0] sum;
  logic [1:0]       combo_inc;

  // Events are refused while the block is in reset or starting a new game.
  assign event_ready = !reset_n && !game_clear;
  assign accept      = event_valid && event_ready;

  // Points for the presented event. A ghost is scored with the combo level
  // held before this edge.
  always_comb begin
    pts = '0;
    case (event_type)
      EV_PELLET: pts = SUM_W'(PELLET_PTS);
      EV_POWER:  pts = SUM_W'(POWER_PTS);
      EV_GHOST:  pts = SUM_W'(GHOST_BASE) << combo;
      EV_FRUIT:  pts = SUM_W'(FRUIT_PTS);
      default:   pts = '0;
    endcase
  end

  assign sum       = {{(SUM_W-SCORE_W){1'b0}}, score} + pts;
  assign combo_inc = (combo >= COMBO_TOP) ? COMBO_TOP : combo + 2'd1;

  // All state updates live here. high_score and the extra-life check both
  // look at the score value held before this edge, so each of them runs one
  // cycle behind score. A power-mode change overrides a ghost combo increment
  // on the same edge.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      score      <= '0;
      high_score <= '0;
      combo      <= '0;
      extra_life <= 1'b0;
      saturated  <= 1'b0;
      life_given <= 1'b0;
    end else if (game_clear) begin
      score      <= '0;
      combo      <= '0;
      extra_life <= 1'b0;
      saturated  <= 1'b0;
      life_given <= 1'b0;
    end else begin
      if (score > high_score) begin
        high_score <= score;
      end

      if ((SUM_W'(score) >= LIFE_LIMIT) && !life_given) begin
        extra_life <= 1'b1;
        life_given <= 1'b1;
      end else begin
        extra_life <= 1'b0;
      end

      if (accept) begin
        if (sum > SCORE_MAX) begin
          score     <= '1;
          saturated <= 1'b1;
        end else begin
          score <= sum[SCORE_W-1:0];
        end
      end

      if (power_start || power_end) begin
        combo <= '0;
      end else if (accept && (event_type == EV_GHOST)) begin
        combo <= combo_inc;
      end
    end
  end

endmodule

// File: tb/tb_score_engine.sv
// tb_score_engine
//   Testbench for score_engine. It drives a 24-bit instance and an 8-bit
//   instance from the same inputs. Each instance is compared against a
//   behavioural game-score model. The directed scenarios cover reset,
//   back-to-back events, the ghost combo, extra life and saturation. A
//   randomized phase follows them.
module tb_score_engine;

  logic        clk;
  logic        reset_n;
  logic        game_clear;
  logic        power_start;
  logic        power_end;
  logic        event_valid;
  logic [1:0]  event_type;

  logic        ready24, ready8;
  logic [23:0] score24, high24;
  logic [7:0]  score8, high8;
  logic [1:0]  combo24, combo8;
  logic        life24, life8, sat24, sat8;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: index 0 is the 24-bit game, index 1 the 8-bit game.
  longint m_score[2];
  longint m_high[2];
  longint m_limit[2];
  int     m_combo[2];
  bit     m_sat[2];
  bit     m_given[2];
  bit     m_life[2];

  longint a_score[2];
  longint a_high[2];
  int     a_combo[2];
  bit     a_sat[2];
  bit     a_life[2];

  score_engine dut24 (
    .clk(clk), .reset_n(reset_n), .game_clear(game_clear),
    .power_start(power_start), .power_end(power_end),
    .event_valid(event_valid), .event_type(event_type),
    .event_ready(ready24), .score(score24), .high_score(high24),
    .combo(combo24), .extra_life(life24), .saturated(sat24)
  );

  score_engine #(.SCORE_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .game_clear(game_clear),
    .power_start(power_start), .power_end(power_end),
    .event_valid(event_valid), .event_type(event_type),
    .event_ready(ready8), .score(score8), .high_score(high8),
    .combo(combo8), .extra_life(life8), .saturated(sat8)
  );

  // Gather both instances into arrays so the random phase can loop over them.
  always_comb begin
    a_score[0] = longint'(score24);
    a_score[1] = longint'(score8);
    a_high[0]  = longint'(high24);
    a_high[1]  = longint'(high8);
    a_combo[0] = int'(combo24);
    a_combo[1] = int'(combo8);
    a_sat[0]   = sat24;
    a_sat[1]   = sat8;
    a_life[0]  = life24;
    a_life[1]  = life8;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Game-level model of a single clock edge, built from the scoring rules:
  // points per event kind, clamping at the width limit, combo rules,
  // a high score that lags by one cycle, and a single life per game.
  task automatic model_step(input int k);
    longint old_score;
    longint add;
    int     old_combo;
    if (reset_n) begin
      m_score[k] = 0; m_high[k] = 0; m_combo[k] = 0;
      m_sat[k] = 0; m_given[k] = 0; m_life[k] = 0;
    end else if (game_clear) begin
      m_score[k] = 0; m_combo[k] = 0;
      m_sat[k] = 0; m_given[k] = 0; m_life[k] = 0;
    end else begin
      old_score = m_score[k];
      old_combo = m_combo[k];
      if (old_score > m_high[k]) m_high[k] = old_score;
      if (old_score >= 10000 && !m_given[k]) begin
        m_life[k] = 1; m_given[k] = 1;
      end else begin
        m_life[k] = 0;
      end
      if (event_valid) begin
        case (event_type)
          2'b00:   add = 10;
          2'b01:   add = 50;
          2'b10:   add = 200 * (longint'(1) << old_combo);
          default: add = 100;
        endcase
        if (old_score + add > m_limit[k]) begin
          m_score[k] = m_limit[k];
          m_sat[k]   = 1;
        end else begin
          m_score[k] = old_score + add;
        end
        if (event_type == 2'b10) m_combo[k] = (old_combo + 1 > 3) ? 3 : old_combo + 1;
      end
      if (power_start || power_end) m_combo[k] = 0;
    end
  endtask

  // One clock edge: the model steps at the same edge as the DUT, then
  // outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  task automatic set_idle();
    reset_n     = 1'b0;
    game_clear  = 1'b0;
    power_start = 1'b0;
    power_end   = 1'b0;
    event_valid = 1'b0;
    event_type  = 2'b00;
  endtask

  task automatic test_reset();
    reset_n     = 1'b1;
    event_valid = 1'b1;
    event_type  = 2'(($urandom));
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (ready24 !== 1'b0 || ready8 !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_ready: got %b/%b expected 0/0", ready24, ready8);
      end
      tick();
      tests_run++;
      if ({score24, high24, combo24, life24, sat24} !== '0 ||
          {score8, high8, combo8, life8, sat8} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs: score %0d/%0d high %0d/%0d combo %0d life %b sat %b expected all 0",
                 score24, score8, high24, high8, combo24, life24, sat24);
      end
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    int exp_score[4] = '{10, 20, 30, 80};
    int exp_high[4]  = '{0, 0, 10, 20};
    logic [1:0] kinds[4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    // high_score still shows 0 after the first edge: it trails score by one
    // cycle, so it lags the score sequence 0,10,20,30.
    exp_high[1] = 10; exp_high[2] = 20; exp_high[3] = 30;
    for (int i = 0; i < 4; i++) begin
      event_valid = 1'b1;
      event_type  = kinds[i];
      tick();
      tests_run++;
      if (score24 !== 24'(exp_score[i])) begin
        tests_failed++;
        $display("[TB] FAIL b2b_score[%0d]: got %0d expected %0d", i, score24, exp_score[i]);
      end
      tests_run++;
      if (high24 !== 24'(exp_high[i])) begin
        tests_failed++;
        $display("[TB] FAIL b2b_high[%0d]: got %0d expected %0d", i, high24, exp_high[i]);
      end
    end
    set_idle();
    tick();
    tests_run++;
    if (high24 !== 24'd80) begin
      tests_failed++;
      $display("[TB] FAIL b2b_high_final: got %0d expected 80", high24);
    end
  endtask

  task automatic test_ghost_combo();
    int exp_score[5] = '{200, 600, 1400, 3000, 4600};
    int exp_combo[5] = '{1, 2, 3, 3, 3};
    game_clear = 1'b1;
    tick();
    game_clear  = 1'b0;
    power_start = 1'b1;
    tick();
    power_start = 1'b0;
    event_valid = 1'b1;
    event_type  = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (score24 !== 24'(exp_score[i]) || combo24 !== 2'(exp_combo[i])) begin
        tests_failed++;
        $display("[TB] FAIL ghost[%0d]: got score %0d combo %0d expected score %0d combo %0d",
                 i, score24, combo24, exp_score[i], exp_combo[i]);
      end
    end
    power_end = 1'b1;
    tick();
    tests_run++;
    if (score24 !== 24'd6200 || combo24 !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL ghost_power_end: got score %0d combo %0d expected 6200 0", score24, combo24);
    end
    tests_run++;
    if (score8 !== 8'd255 || sat8 !== 1'b1 || combo8 !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL ghost_narrow: got score %0d sat %b combo %0d expected 255 1 0", score8, sat8, combo8);
    end
    set_idle();
  endtask

  task automatic test_extra_life();
    int pulses;
    int pulse_at;
    game_clear = 1'b1;
    tick();
    game_clear  = 1'b0;
    event_valid = 1'b1;
    event_type  = 2'b00;
    pulses = 0;
    for (int i = 0; i < 999; i++) begin
      tick();
      if (life24) pulses++;
    end
    tests_run++;
    if (score24 !== 24'd9990 || pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL life_preload: got score %0d pulses %0d expected 9990 0", score24, pulses);
    end
    tick();
    tests_run++;
    if (score24 !== 24'd10000 || life24 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL life_cross: got score %0d life %b expected 10000 0", score24, life24);
    end
    event_valid = 1'b0;
    tick();
    tests_run++;
    if (life24 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL life_pulse: got %b expected 1", life24);
    end
    tick();
    tests_run++;
    if (life24 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL life_one_cycle: got %b expected 0", life24);
    end
    event_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (life24) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL life_no_refire: got %0d pulses expected 0", pulses);
    end
    game_clear = 1'b1;
    tick();
    game_clear = 1'b0;
    pulses   = 0;
    pulse_at = -1;
    for (int i = 1; i <= 1003; i++) begin
      event_valid = (i <= 1000);
      tick();
      if (life24) begin
        pulses++;
        pulse_at = i;
      end
    end
    tests_run++;
    if (pulses != 1 || pulse_at != 1001) begin
      tests_failed++;
      $display("[TB] FAIL life_after_clear: got %0d pulses at tick %0d expected 1 at tick 1001", pulses, pulse_at);
    end
    set_idle();
  endtask

  task automatic test_saturation();
    game_clear = 1'b1;
    tick();
    game_clear  = 1'b0;
    event_valid = 1'b1;
    event_type  = 2'b00;
    for (int i = 0; i < 25; i++) tick();
    tests_run++;
    if (score8 !== 8'd250 || sat8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sat_preload: got score %0d sat %b expected 250 0", score8, sat8);
    end
    event_type = 2'b10;
    tick();
    tests_run++;
    if (score8 !== 8'd255 || sat8 !== 1'b1 || score24 !== 24'd450) begin
      tests_failed++;
      $display("[TB] FAIL sat_clamp: got score8 %0d sat %b score24 %0d expected 255 1 450", score8, sat8, score24);
    end
    event_valid = 1'b0;
    tick();
    tests_run++;
    if (high8 !== 8'd255 || sat8 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sat_high: got high %0d sat %b expected 255 1", high8, sat8);
    end
    game_clear  = 1'b1;
    event_valid = 1'b1;
    event_type  = 2'b00;
    #1;
    tests_run++;
    if (ready8 !== 1'b0 || ready24 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_ready: got %b/%b expected 0/0", ready24, ready8);
    end
    tick();
    tests_run++;
    if (score8 !== 8'd0 || sat8 !== 1'b0 || high8 !== 8'd255 || score24 !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_state: got score8 %0d sat %b high8 %0d score24 %0d expected 0 0 255 0",
               score8, sat8, high8, score24);
    end
    set_idle();
    tick();
    tests_run++;
    if (score8 !== 8'd0 || score24 !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_drop: got score8 %0d score24 %0d expected 0 0", score8, score24);
    end
  endtask

  task automatic test_random();
    bit exp_ready;
    for (int n = 0; n < 3000; n++) begin
      reset_n     = ($urandom_range(0, 999) == 0);
      game_clear  = ($urandom_range(0, 499) == 0);
      power_start = ($urandom_range(0, 15) == 0);
      power_end   = ($urandom_range(0, 15) == 0);
      event_valid = ($urandom_range(0, 3) != 0);
      event_type  = 2'($urandom_range(0, 3));
      exp_ready   = !reset_n && !game_clear;
      #1;
      tests_run++;
      if (ready24 !== exp_ready || ready8 !== exp_ready) begin
        tests_failed++;
        $display("[TB] FAIL rand_ready[%0d]: got %b/%b expected %b", n, ready24, ready8, exp_ready);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (a_score[k] != m_score[k] || a_high[k] != m_high[k] || a_combo[k] != m_combo[k] ||
            a_sat[k] != m_sat[k] || a_life[k] != m_life[k]) begin
          tests_failed++;
          $display("[TB] FAIL rand[%0d] inst%0d: got score %0d high %0d combo %0d sat %b life %b expected %0d %0d %0d %b %b",
                   n, k, a_score[k], a_high[k], a_combo[k], a_sat[k], a_life[k],
                   m_score[k], m_high[k], m_combo[k], m_sat[k], m_life[k]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    m_limit[0] = (longint'(1) << 24) - 1;
    m_limit[1] = 255;
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0; m_high[k] = 0; m_combo[k] = 0;
      m_sat[k] = 0; m_given[k] = 0; m_life[k] = 0;
    end
    set_idle();
    reset_n = 1'b1;
    #2;
    test_reset();
    test_back_to_back();
    test_ghost_combo();
    test_extra_life();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
